// File: rtl/spi_atten_pkg.sv
// spi_atten_pkg: shared state encoding, default timing constants and clog2 for the SPI attenuator scheduler
package spi_atten_pkg;
  typedef enum logic [2:0] {
    S_FLUSH = 3'd0,
    S_IDLE  = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
  } state_t;
  localparam int DEF_TXN_CYCLES = 1250000;
  localparam int DEF_GAP_CYCLES = 64;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: rotating priority encoder; first set request at or above i_rr_ptr, wrapping (ports: i_req, i_rr_ptr -> o_any_req, o_grant_idx)
module spi_rr_arbiter
  import spi_atten_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_rr_ptr,
  output logic               o_any_req,
  output logic [IW-1:0]      o_grant_idx
);
  logic [IW-1:0] w_sel;
  always_comb begin
    o_any_req   = |i_req;
    o_grant_idx = '0;
    w_sel       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sel = IW'((int'(i_rr_ptr) + k) % NUM_REQ);
      o_grant_idx = i_req[w_sel] ? w_sel : o_grant_idx;
    end
  end
endmodule

// File: rtl/spi_atten_scheduler.sv
// spi_atten_scheduler: round-robin sharing of one SPI serializer among NUM_REQ requesters; ports clk/rst, req/req_data in, ack/grant_id/busy/ser_ld/ser_data out
module spi_atten_scheduler
  import spi_atten_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 32,
  parameter int TXN_CYCLES = DEF_TXN_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  localparam int IW        = clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [IW-1:0]             grant_id,
  output logic                      busy,
  output logic                      ser_ld,
  output logic [DATA_W-1:0]         ser_data
);
  state_t        r_state;
  logic [31:0]   r_cnt;
  logic [IW-1:0] r_rr_ptr;
  logic          w_any;
  logic [IW-1:0] w_idx;
  spi_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .i_req       (req),
    .i_rr_ptr    (r_rr_ptr),
    .o_any_req   (w_any),
    .o_grant_idx (w_idx)
  );
  assign busy = (r_state != S_IDLE);
  // FLUSH after reset covers a frame the unreset serializer may still be shifting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FLUSH;
      r_cnt    <= 32'(TXN_CYCLES - 1);
      r_rr_ptr <= '0;
      ack      <= '0;
      ser_ld   <= 1'b0;
      ser_data <= '0;
      grant_id <= '0;
    end else begin
      ack    <= '0;
      ser_ld <= 1'b0;
      case (r_state)
        S_FLUSH: begin
          r_cnt   <= (r_cnt == 0) ? r_cnt : r_cnt - 1'b1;
          r_state <= (r_cnt == 0) ? S_IDLE : S_FLUSH;
        end
        S_IDLE: if (w_any) begin
          grant_id <= w_idx;
          ser_data <= req_data[int'(w_idx)*DATA_W +: DATA_W];
          ser_ld   <= 1'b1;
          r_state  <= S_LOAD;
        end
        S_LOAD: begin
          r_cnt   <= 32'(TXN_CYCLES - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: if (r_cnt == 0) begin
          ack[grant_id] <= 1'b1;
          r_rr_ptr      <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          r_cnt         <= 32'(GAP_CYCLES - 1);
          r_state       <= S_GAP;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        S_GAP: begin
          r_cnt   <= (r_cnt == 0) ? r_cnt : r_cnt - 1'b1;
          r_state <= (r_cnt == 0) ? S_IDLE : S_GAP;
        end
        default: r_state <= S_FLUSH;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_atten_scheduler.sv
// tb_spi_atten_scheduler: directed self-checking bench for spi_atten_scheduler (TXN_CYCLES=20, GAP_CYCLES=3)
module tb_spi_atten_scheduler;
  localparam int N = 4;
  localparam int W = 32;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic [1:0]     grant_id;
  logic           busy;
  logic           ser_ld;
  logic [W-1:0]   ser_data;
  int n_chk = 0;
  int n_err = 0;
  int ack_cnt [N];
  int snap [N];
  spi_atten_scheduler #(
    .NUM_REQ(N), .DATA_W(W), .TXN_CYCLES(20), .GAP_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack), .grant_id(grant_id), .busy(busy), .ser_ld(ser_ld), .ser_data(ser_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (ack != 0) begin
    chk("ack_onehot", 64'($onehot(ack)), 64'd1);
    for (int i = 0; i < N; i++) if (ack[i]) ack_cnt[i]++;
  end
  task automatic set_word(input logic [1:0] ch, input logic [31:0] w);
    req_data[int'(ch)*W +: W] = w;
  endtask
  task automatic wait_ld(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ser_ld && n < 100);
    chk({tag, "_ld_lat"}, 64'(n), 64'(exp));
  endtask
  task automatic run_frame(input string tag, input logic [1:0] id, input logic [31:0] word,
                           input bit drop, input logic [3:0] raise, input bit mutate);
    int n;
    logic [3:0] one;
    one = 4'b0001 << id;
    n = 0;
    chk({tag, "_ld"}, 64'(ser_ld), 64'd1);
    chk({tag, "_data"}, 64'(ser_data), 64'(word));
    chk({tag, "_gid"}, 64'(grant_id), 64'(id));
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({tag, "_ld_pulse"}, 64'(ser_ld), 64'd0);
        if (mutate) begin
          req[id] = 1'b0;
          set_word(id, ~word);
        end
      end
      if (n == 5) req = req | raise;
    end while (ack == 0 && n < 100);
    chk({tag, "_ack_lat"}, 64'(n), 64'd21);
    chk({tag, "_ack"}, 64'(ack), 64'(one));
    chk({tag, "_data_hold"}, 64'(ser_data), 64'(word));
    if (drop) req[id] = 1'b0;
  endtask
  task automatic idle_gap(input string tag);
    @(negedge clk);
    chk({tag, "_gap_busy"}, 64'(busy), 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask
  initial begin
    set_word(0, 32'h1111_0000);
    set_word(1, 32'h2222_0001);
    set_word(2, 32'h3333_0002);
    set_word(3, 32'h4444_0003);
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_ld", 64'(ser_ld), 64'd0);
    chk("rst_data", 64'(ser_data), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    rst = 1'b0;
    req = 4'b0001;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'd1);
    wait_ld("t1_flush", 20);
    run_frame("t1", 2'd0, 32'h1111_0000, 1'b1, 4'b0000, 1'b0);
    idle_gap("t1");
    set_word(2, 32'h00A5_5A01);
    req = 4'b0100;
    wait_ld("t2", 1);
    run_frame("t2", 2'd2, 32'h00A5_5A01, 1'b1, 4'b0000, 1'b0);
    idle_gap("t2");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < N; i++) snap[i] = ack_cnt[i];
    wait_ld("t3_flush", 21);
    run_frame("t3_c0", 2'd0, 32'h1111_0000, 1'b1, 4'b0000, 1'b0);
    wait_ld("t3_c1", 4);
    run_frame("t3_c1", 2'd1, 32'h2222_0001, 1'b1, 4'b0000, 1'b0);
    wait_ld("t3_c2", 4);
    run_frame("t3_c2", 2'd2, 32'h00A5_5A01, 1'b1, 4'b0000, 1'b0);
    wait_ld("t3_c3", 4);
    run_frame("t3_c3", 2'd3, 32'h4444_0003, 1'b1, 4'b0000, 1'b0);
    idle_gap("t3");
    for (int i = 0; i < N; i++) chk("t3_once", 64'(ack_cnt[i] - snap[i]), 64'd1);
    set_word(1, 32'hCAFE_0101);
    set_word(3, 32'hBEEF_0303);
    req = 4'b0010;
    wait_ld("t4_c1", 1);
    run_frame("t4_c1", 2'd1, 32'hCAFE_0101, 1'b0, 4'b1000, 1'b0);
    wait_ld("t4_c3", 4);
    run_frame("t4_c3", 2'd3, 32'hBEEF_0303, 1'b1, 4'b0000, 1'b0);
    wait_ld("t4_c1b", 4);
    run_frame("t4_c1b", 2'd1, 32'hCAFE_0101, 1'b1, 4'b0000, 1'b0);
    idle_gap("t4");
    set_word(2, 32'h5A5A_0202);
    req = 4'b0100;
    wait_ld("t5", 1);
    chk("t5_gid", 64'(grant_id), 64'd2);
    repeat (10) @(negedge clk);
    snap[2] = ack_cnt[2];
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_busy", 64'(busy), 64'd1);
    chk("t5_rst_ld", 64'(ser_ld), 64'd0);
    chk("t5_rst_data", 64'(ser_data), 64'd0);
    chk("t5_rst_ack", 64'(ack), 64'd0);
    rst = 1'b0;
    wait_ld("t5_flush", 21);
    chk("t5_no_ack", 64'(ack_cnt[2]), 64'(snap[2]));
    run_frame("t5", 2'd2, 32'h5A5A_0202, 1'b1, 4'b0000, 1'b0);
    idle_gap("t5");
    set_word(0, 32'h0F0F_7777);
    req = 4'b0001;
    wait_ld("t6", 1);
    run_frame("t6", 2'd0, 32'h0F0F_7777, 1'b1, 4'b0000, 1'b1);
    idle_gap("t6");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
